// File: rtl/fifo_wr_arbiter_pkg.sv
// ============================================================================
// Module : fifo_pkg
// Brief  : Shared types and helpers for the FIFO write-port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    // Beat counter width; covers packet limits up to 255.
    localparam int c_beat_cnt_w = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
// ============================================================================
// Module : fifo_wr_arbiter_if
// Brief  : Producer streams plus FIFO write-port bundle for the arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_wr_arbiter_if
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int c_idx_w = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic [c_idx_w-1:0]            grant_id;
    logic                          busy;
    logic                          overrun;

    modport master (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, overrun
    );

    modport slave (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, overrun
    );

endinterface

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_find_first.sv
// ============================================================================
// Module : rr_find_first
// Brief  : First set request scanning from ptr upward, wrapping at NUM_REQ.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_find_first
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic [IDX_W-1:0]   ptr,
    output logic                    found,
    output logic [IDX_W-1:0]        idx
);

    logic [IDX_W:0] w_pos;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        w_pos = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (w_pos >= (IDX_W + 1)'(NUM_REQ)) begin
                w_pos = w_pos - (IDX_W + 1)'(NUM_REQ);
            end
            if (req[w_pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module : fifo_wr_arbiter
// Brief  : Packet-granular round-robin arbiter for a single FIFO write port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fifo_wr_arbiter_if.master  bus
);

    localparam int                      c_idx_w     = idx_width(NUM_REQ);
    localparam logic [c_idx_w-1:0]      c_last_idx  = c_idx_w'(NUM_REQ - 1);
    localparam logic [c_beat_cnt_w-1:0] c_max_beats = c_beat_cnt_w'(MAX_BEATS);

    arb_state_e              state_q, state_d;
    logic [c_idx_w-1:0]      ptr_q, ptr_d;
    logic [c_idx_w-1:0]      owner_q, owner_d;
    logic [c_beat_cnt_w-1:0] beats_q, beats_d;
    logic                    overrun_q, overrun_d;

    logic                    w_ff_found;
    logic [c_idx_w-1:0]      w_ff_idx;
    logic [c_idx_w-1:0]      w_sel;
    logic                    w_sel_valid;
    logic                    w_sel_last;
    logic                    w_grant_ok;
    logic                    w_xfer;

    function automatic logic [c_idx_w-1:0] wrap_inc(input logic [c_idx_w-1:0] x);
        return (x == c_last_idx) ? '0 : x + c_idx_w'(1);
    endfunction

    rr_find_first #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_find (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .found (w_ff_found),
        .idx   (w_ff_idx)
    );

    always_comb begin
        w_sel       = ptr_q;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        if (state_q == LOCKED) begin
            w_sel = owner_q;
        end else if (w_ff_found) begin
            w_sel = w_ff_idx;
        end
        bus.fifo_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == c_idx_w'(i)) begin
                w_sel_valid      = bus.req_valid[i];
                w_sel_last       = bus.req_last[i];
                bus.fifo_wr_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        // In IDLE nothing is offered until someone is valid; the owner always is.
        w_grant_ok = (state_q == LOCKED) || (|bus.req_valid);
        w_xfer     = !rst && w_sel_valid && !bus.fifo_full && w_grant_ok;

        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == c_idx_w'(i)) begin
                bus.req_ready[i] = !rst && w_grant_ok && !bus.fifo_full;
            end
        end
        bus.fifo_wr_en = w_xfer;
        bus.grant_id   = rst ? '0 : w_sel;
        bus.busy       = !rst && (state_q == LOCKED);
        bus.overrun    = overrun_q;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        beats_d   = beats_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (w_xfer) begin
                    if (w_sel_last) begin
                        ptr_d = wrap_inc(w_sel);
                    end else begin
                        state_d = LOCKED;
                        owner_d = w_sel;
                        beats_d = c_beat_cnt_w'(1);
                    end
                end
            end
            LOCKED: begin
                if (w_xfer) begin
                    if (w_sel_last) begin
                        state_d = IDLE;
                        ptr_d   = wrap_inc(owner_q);
                        beats_d = '0;
                    end else if (beats_q == c_max_beats) begin
                        // Lock is kept; the flag is diagnostic only.
                        overrun_d = 1'b1;
                    end else begin
                        beats_d = beats_q + c_beat_cnt_w'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            beats_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            beats_q   <= beats_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module : tb_fifo_wr_arbiter
// Brief  : Directed vector bench for the FIFO write-port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    logic clk;
    logic rst;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus4 ();
    fifo_wr_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8)) bus3 ();

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BEATS  (4)
    ) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    fifo_wr_arbiter #(
        .NUM_REQ    (3),
        .DATA_WIDTH (8),
        .MAX_BEATS  (16)
    ) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] l;
        logic       full;
        logic [3:0] ready;
        logic       wr;
        logic [1:0] grant;
        logic       busy;
        logic       ov;
    } vec_t;

    localparam int c_nvec = 35;
    vec_t tbl [c_nvec];
    int   n_vec;
    int   n_err;

    function automatic vec_t mk(input int r, input int v, input int l, input int f,
                                input int rdy, input int wr, input int g,
                                input int b, input int o);
        vec_t t;
        t.rst   = 1'(r);
        t.v     = 4'(v);
        t.l     = 4'(l);
        t.full  = 1'(f);
        t.ready = 4'(rdy);
        t.wr    = 1'(wr);
        t.grant = 2'(g);
        t.busy  = 1'(b);
        t.ov    = 1'(o);
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic step3(input int idx, input logic [2:0] v, input logic [2:0] l,
                         input logic [2:0] rdy, input logic wr, input logic [1:0] g,
                         input logic b);
        logic [23:0] d;
        @(negedge clk);
        for (int j = 0; j < 3; j++) d[j*8 +: 8] = {4'(j), 4'(idx)};
        bus3.req_valid = v;
        bus3.req_last  = l;
        bus3.req_data  = d;
        bus3.fifo_full = 1'b0;
        #1;
        n_vec++;
        chk("n3_ready", idx, 32'(bus3.req_ready), 32'(rdy));
        chk("n3_wr_en", idx, 32'(bus3.fifo_wr_en), 32'(wr));
        chk("n3_grant", idx, 32'(bus3.grant_id), 32'(g));
        chk("n3_busy",  idx, 32'(bus3.busy), 32'(b));
        chk("n3_data",  idx, 32'(bus3.fifo_wr_data), 32'({2'b00, g, 4'(idx)}));
    endtask

    initial begin
        logic [31:0] d;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus4.req_valid = '0; bus4.req_last = '0; bus4.req_data = '0; bus4.fifo_full = 1'b0;
        bus3.req_valid = '0; bus3.req_last = '0; bus3.req_data = '0; bus3.fifo_full = 1'b0;

        //           rst  v    l    full rdy wr g  busy ov
        tbl[0]  = mk(1, 'hF, 'hF, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 'hF, 'hF, 0,  1, 1, 0, 0, 0);
        tbl[2]  = mk(0, 'hF, 'hF, 0,  2, 1, 1, 0, 0);
        tbl[3]  = mk(0, 'hF, 'hF, 0,  4, 1, 2, 0, 0);
        tbl[4]  = mk(0, 'hF, 'hF, 0,  8, 1, 3, 0, 0);
        tbl[5]  = mk(0, 'hF, 'hF, 0,  1, 1, 0, 0, 0);
        tbl[6]  = mk(0, 'h6, 'h4, 0,  2, 1, 1, 0, 0);
        tbl[7]  = mk(0, 'h6, 'h4, 0,  2, 1, 1, 1, 0);
        tbl[8]  = mk(0, 'h6, 'h6, 0,  2, 1, 1, 1, 0);
        tbl[9]  = mk(0, 'h4, 'h4, 0,  4, 1, 2, 0, 0);
        tbl[10] = mk(0, 'h1, 'h0, 0,  1, 1, 0, 0, 0);
        tbl[11] = mk(0, 'h9, 'h0, 1,  0, 0, 0, 1, 0);
        tbl[12] = mk(0, 'h9, 'h0, 1,  0, 0, 0, 1, 0);
        tbl[13] = mk(0, 'h9, 'h0, 1,  0, 0, 0, 1, 0);
        tbl[14] = mk(0, 'h9, 'h0, 1,  0, 0, 0, 1, 0);
        tbl[15] = mk(0, 'h9, 'h0, 0,  1, 1, 0, 1, 0);
        tbl[16] = mk(0, 'h9, 'h1, 0,  1, 1, 0, 1, 0);
        tbl[17] = mk(0, 'h8, 'h8, 0,  8, 1, 3, 0, 0);
        tbl[18] = mk(0, 'h2, 'h0, 0,  2, 1, 1, 0, 0);
        tbl[19] = mk(0, 'h4, 'h4, 0,  2, 0, 1, 1, 0);
        tbl[20] = mk(0, 'h2, 'h2, 0,  2, 1, 1, 1, 0);
        tbl[21] = mk(0, 'h0, 'h0, 0,  0, 0, 2, 0, 0);
        tbl[22] = mk(0, 'h4, 'h4, 1,  0, 0, 2, 0, 0);
        tbl[23] = mk(0, 'h2, 'h0, 0,  2, 1, 1, 0, 0);
        tbl[24] = mk(0, 'h2, 'h0, 0,  2, 1, 1, 1, 0);
        tbl[25] = mk(0, 'h2, 'h0, 0,  2, 1, 1, 1, 0);
        tbl[26] = mk(0, 'h2, 'h0, 0,  2, 1, 1, 1, 0);
        tbl[27] = mk(0, 'h2, 'h0, 0,  2, 1, 1, 1, 0);
        tbl[28] = mk(0, 'h2, 'h2, 0,  2, 1, 1, 1, 1);
        tbl[29] = mk(0, 'h0, 'h0, 0,  0, 0, 2, 0, 1);
        tbl[30] = mk(0, 'h4, 'h0, 0,  4, 1, 2, 0, 1);
        tbl[31] = mk(0, 'h4, 'h0, 0,  4, 1, 2, 1, 1);
        tbl[32] = mk(1, 'h5, 'h0, 0,  0, 0, 0, 0, 1);
        tbl[33] = mk(0, 'h5, 'h5, 0,  1, 1, 0, 0, 0);
        tbl[34] = mk(0, 'h4, 'h4, 0,  4, 1, 2, 0, 0);

        for (int i = 0; i < c_nvec; i++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) d[j*8 +: 8] = {4'(j), 4'(i)};
            rst            = tbl[i].rst;
            bus4.req_valid = tbl[i].v;
            bus4.req_last  = tbl[i].l;
            bus4.req_data  = d;
            bus4.fifo_full = tbl[i].full;
            #1;
            n_vec++;
            chk("ready",   i, 32'(bus4.req_ready),  32'(tbl[i].ready));
            chk("wr_en",   i, 32'(bus4.fifo_wr_en), 32'(tbl[i].wr));
            chk("grant",   i, 32'(bus4.grant_id),   32'(tbl[i].grant));
            chk("busy",    i, 32'(bus4.busy),       32'(tbl[i].busy));
            chk("overrun", i, 32'(bus4.overrun),    32'(tbl[i].ov));
            if (!tbl[i].rst) begin
                chk("wr_data", i, 32'(bus4.fifo_wr_data),
                    32'({2'b00, tbl[i].grant, 4'(i)}));
            end
        end

        @(negedge clk);
        bus4.req_valid = '0;
        bus4.req_last  = '0;

        // Three requesters: pointer must wrap from 2 back to 0 after req2's packet.
        step3(1, 3'b100, 3'b000, 3'b100, 1'b1, 2'd2, 1'b0);
        step3(2, 3'b101, 3'b100, 3'b100, 1'b1, 2'd2, 1'b1);
        step3(3, 3'b101, 3'b101, 3'b001, 1'b1, 2'd0, 1'b0);
        step3(4, 3'b100, 3'b100, 3'b100, 1'b1, 2'd2, 1'b0);
        step3(5, 3'b011, 3'b011, 3'b001, 1'b1, 2'd0, 1'b0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single write port of one sync_fifo instance between NUM_REQ producers.
- Each producer offers a valid/ready stream of packets, with a last marker on the final beat.
- Grants rotate round-robin at packet granularity. Once a packet starts, its owner holds the port until that packet's last beat is accepted, so packets never interleave in the FIFO.
- Sits between producer pipelines and the FIFO's wr_en/wr_data/full signals.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16, need not be a power of two.
- DATA_WIDTH, 8, beat width; must equal the FIFO DATA_WIDTH.
- MAX_BEATS, 16, packet-length limit used for overrun detection; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester last-beat marker; qualified by req_valid
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  beat accepted when req_valid[i] && req_ready[i]
- fifo_full  in  1  from FIFO full
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_wr_data  out  DATA_WIDTH  to FIFO wr_data
- grant_id  out  max(1,$clog2(NUM_REQ))  current selected requester
- busy  out  1  high while a packet is in progress (LOCKED)
- overrun  out  1  sticky packet-too-long flag

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state IDLE, ptr=0, owner=0, beats=0, overrun=0.
- Outputs while rst is high: req_ready=0, fifo_wr_en=0, busy=0, grant_id=0.
- Transfer definition: xfer = req_valid[sel] && !fifo_full && (state==LOCKED || any req_valid).
  - req_ready is one-hot on sel and equals !fifo_full; all other bits are 0.
  - fifo_wr_en = xfer (combinational).
  - fifo_wr_data = req_data slice for sel, driven even when fifo_wr_en=0.
  - Zero-latency path: the FIFO write occurs on the same edge the producer sees its handshake.
- IDLE state:
  - sel = first i with req_valid[i], scanning ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - If no requester is valid: sel=ptr, req_ready=0.
  - Selection is not committed until a transfer occurs. If fifo_full, sel may change next cycle when other requests arrive.
  - xfer && req_last[sel]: stay in IDLE; ptr <= (sel+1) mod NUM_REQ (single-beat packet).
  - xfer && !req_last[sel]: go to LOCKED; owner <= sel; beats <= 1.
- LOCKED state:
  - sel = owner, regardless of other valids. Owner bubbles (req_valid low) keep the lock.
  - xfer && req_last: go to IDLE; ptr <= (owner+1) mod NUM_REQ; beats <= 0.
  - xfer && !req_last: beats <= beats+1, saturating at MAX_BEATS.
  - A non-last transfer while beats==MAX_BEATS sets overrun. The lock is still held, so overrun is a diagnostic only.
- Status outputs:
  - busy = (state==LOCKED).
  - grant_id = sel.
  - overrun clears only on rst.
- Wrap-around: ptr and owner increment compares against NUM_REQ-1 explicitly; no power-of-two reliance.
- Reset mid-packet: the lock is dropped. The partial packet already in the FIFO is the owner's problem; the arbiter does not flush the FIFO.
- fifo_full asserted mid-packet: the owner stalls and the lock is held; no other requester gains access.

Decomposition:
- Shared package (fifo_pkg): the clog2-based index-width constant, plus state enum values IDLE=0 and LOCKED=1 (1-bit state register).
- One natural combinational sub-module: rr_find_first (NUM_REQ param; inputs req vector and ptr; outputs found and idx).
- The FSM, counters and muxing stay in fifo_wr_arbiter.

Test Plan:
- NUM_REQ=4, all four hold single-beat packets continuously, FIFO never full -> grant_id sequence 0,1,2,3,0 on consecutive cycles; one fifo_wr_en per cycle.
- Req1 sends a 3-beat packet while req2 is valid throughout -> grant_id=1 for 3 transfers, busy=1 after the first beat; req2 is first granted the cycle after req1's last beat.
- Req0 mid-packet with fifo_full=1 for 4 cycles, req3 valid -> fifo_wr_en=0 and req_ready=0 throughout; req0 resumes when full drops; req3 waits until req0's last beat.
- NUM_REQ=3, req2 finishes a packet, then only req0 and req2 are valid -> ptr wraps to 0; req0 is granted next.
- MAX_BEATS=4, req1 sends 6 beats with last on beat 6 -> overrun rises on the 5th accepted beat and stays high after IDLE; all 6 beats are written.
- rst pulsed while LOCKED with owner=2 -> next cycle busy=0, overrun=0, ptr=0; req0 and req2 both valid -> req0 granted.
